// File: rtl/starfield_pkg.sv
// starfield_pkg: shared timing constants, scroll state encoding and pad length helper
package starfield_pkg;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int WIN_BITS = 9;
  localparam int SPEED_W = 4;
  localparam int PAD_W = 14;
  localparam int LFSR_PERIOD = 65535;
  localparam int WIN_MOD = (1 << (2 * WIN_BITS)) % LFSR_PERIOD;
  typedef enum logic [1:0] {WINDOW, PAD, IDLE} scroll_state_t;
  // window already drifts WIN_MOD steps per frame, so the pad tops it up to whole rows
  function automatic logic [PAD_W-1:0] pad_len(input logic [SPEED_W-1:0] s);
    return (s == '0) ? '0 : PAD_W'({s, WIN_BITS'(0)}) - PAD_W'(WIN_MOD);
  endfunction
endpackage

// File: rtl/starfield_pad_counter.sv
// starfield_pad_counter: loadable down-counter that saturates at zero
module starfield_pad_counter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign cnt = cnt_q;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/starfield_scroll_ctrl.sv
// starfield_scroll_ctrl: gates LFSR stepping per frame so the starfield scrolls at a set speed or freezes
module starfield_scroll_ctrl #(
  parameter int H_TOTAL = starfield_pkg::H_TOTAL,
  parameter int V_TOTAL = starfield_pkg::V_TOTAL,
  parameter int WIN_BITS = starfield_pkg::WIN_BITS,
  parameter int SPEED_W = starfield_pkg::SPEED_W,
  parameter int PAD_W = starfield_pkg::PAD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic [SPEED_W-1:0] speed,
  input  logic               speed_req,
  output logic               speed_ack,
  output logic               lfsr_enable,
  output logic               lfsr_reseed,
  output logic [7:0]         frame_count,
  output logic               pad_overrun
);
  import starfield_pkg::*;
  localparam int WIN = 1 << WIN_BITS;
  scroll_state_t state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic speed_ack_q, speed_ack_d, pad_overrun_q, pad_overrun_d;
  logic [PAD_W-1:0] pad_cnt;
  logic pad_zero, frame_end, win_last;
  assign frame_end = hpos == 10'(H_TOTAL - 1) && vpos == 10'(V_TOTAL - 1);
  assign win_last = hpos == 10'(H_TOTAL - 1) && vpos == 10'(WIN - 1);
  starfield_pad_counter #(.W(PAD_W)) u_pad (
    .clk(clk),
    .reset(reset),
    .load(frame_end),
    .load_val(pad_len(speed_d)),
    .dec(lfsr_enable && state_q == PAD),
    .cnt(pad_cnt),
    .zero(pad_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WINDOW;
      speed_q <= '0;
      frame_count_q <= '0;
      speed_ack_q <= 1'b0;
      pad_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      frame_count_q <= frame_count_d;
      speed_ack_q <= speed_ack_d;
      pad_overrun_q <= pad_overrun_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (frame_end) state_d = WINDOW;
    else if (state_q == WINDOW && win_last) state_d = pad_zero ? IDLE : PAD;
    else if (state_q == PAD && pad_cnt <= PAD_W'(1)) state_d = IDLE;
  end
  always_comb begin
    speed_d = (frame_end && speed_req) ? speed : speed_q;
    speed_ack_d = frame_end && speed_req;
    frame_count_d = frame_count_q + 8'(frame_end);
    pad_overrun_d = pad_overrun_q || (frame_end && state_q == PAD && !pad_zero);
  end
  // reseed is left to the top during reset since it resets the LFSR itself
  always_comb begin
    lfsr_enable = !reset && (state_q == PAD || (state_q == WINDOW && hpos < 10'(WIN)));
    lfsr_reseed = !reset && frame_end && speed_d == '0;
  end
  assign speed_ack = speed_ack_q;
  assign frame_count = frame_count_q;
  assign pad_overrun = pad_overrun_q;
endmodule
